// File: rtl/present_pkg.sv
// ============================================================================
// present_pkg : shared PRESENT constants, inverse S-box, state encoding and
//               inverse bit-permutation helper.            Rev 1.0
// ============================================================================
`default_nettype none

package present_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int ROUNDS  = 31;
    localparam int ADDR_W  = 5;

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_WHITEN = 2'd2,
        ST_ROUND  = 2'd3
    } state_t;

    // Forward layer sends bit i to 16*i mod 63, so output bit i gathers from there.
    function automatic logic [BLOCK_W-1:0] inv_player(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLOCK_W - 1; i++) begin
            r[i] = d[(16 * i) % (BLOCK_W - 1)];
        end
        r[BLOCK_W-1] = d[BLOCK_W-1];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/present_inv_round_layer.sv
// ============================================================================
// present_inv_round_layer : combinational inverse P-layer followed by the
//                           inverse S-box on every nibble.   Rev 1.0
// ============================================================================
`default_nettype none

module present_inv_round_layer
    import present_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [BLOCK_W-1:0] perm_w;

    assign perm_w = inv_player(state_i);

    for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_nib
        assign state_o[4*n +: 4] = INV_SBOX[perm_w[4*n +: 4]];
    end

endmodule

`default_nettype wire

// File: rtl/present_dec_round_engine.sv
// ============================================================================
// present_dec_round_engine : iterative PRESENT-80 decryption, one inverse
//   round per clock, round keys read from the shared subkey memory.
//   Optional abort input enabled by `define PRESENT_DEC_ABORT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module present_dec_round_engine #(
    parameter int BLOCK_W = present_pkg::BLOCK_W,
    parameter int ADDR_W  = present_pkg::ADDR_W,
    parameter int ROUNDS  = present_pkg::ROUNDS
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [BLOCK_W-1:0] ciphertext,
    input  logic               start,
`ifdef PRESENT_DEC_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               ready,
    output logic [BLOCK_W-1:0] plaintext,
    output logic [ADDR_W-1:0]  keymem_addr,
    input  logic [BLOCK_W-1:0] subkey
);

    import present_pkg::*;

    localparam int CNT_W = $clog2(ROUNDS + 1);

    state_t             state_q;
    logic [BLOCK_W-1:0] data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLOCK_W-1:0] layer_w;
    logic [BLOCK_W-1:0] round_d;
    logic               abort_hit;

    present_inv_round_layer u_layer (
        .state_i (data_q),
        .state_o (layer_w)
    );

    assign round_d = layer_w ^ subkey;

`ifdef PRESENT_DEC_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            plaintext   <= '0;
            keymem_addr <= '1;
        end else begin
            ready <= 1'b0;
            if (abort_hit) begin
                state_q     <= ST_IDLE;
                data_q      <= '0;
                cnt_q       <= '0;
                busy        <= 1'b0;
                keymem_addr <= '1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            data_q      <= ciphertext;
                            keymem_addr <= '1;
                            busy        <= 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        keymem_addr <= keymem_addr - 1'b1;
                        state_q     <= ST_WHITEN;
                    end
                    ST_WHITEN: begin
                        // subkey now carries K32 for the whitening XOR.
                        data_q      <= data_q ^ subkey;
                        keymem_addr <= keymem_addr - 1'b1;
                        cnt_q       <= CNT_W'(ROUNDS);
                        state_q     <= ST_ROUND;
                    end
                    ST_ROUND: begin
                        data_q <= round_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (keymem_addr != '0) begin
                            keymem_addr <= keymem_addr - 1'b1;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            plaintext   <= round_d;
                            ready       <= 1'b1;
                            busy        <= 1'b0;
                            keymem_addr <= '1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/present_dec_round_engine.md
Name: present_dec_round_engine

Overview:
- Iterative PRESENT-80 decryption datapath: one 64-bit ciphertext block in, one plaintext block out, one inverse round per clock.
- Reads round keys from the shared 32-entry subkey memory (one 64-bit key per address, filled by the subkey generator). It is the reader side of that memory interface.
- Sits beside the encryption engine under the PRESENT top. The top owns the memory and muxes keymem_addr/subkey.

Parameters:
- BLOCK_W, 64, cipher block and subkey width.
- ADDR_W, 5, subkey memory address width (32 entries).
- ROUNDS, 31, number of inverse rounds after the whitening XOR.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- ciphertext  input  BLOCK_W  block to decrypt; sampled only in the cycle start is accepted
- start  input  1  request; accepted only when busy=0
- busy  output  1  high from the cycle after acceptance until ready
- ready  output  1  one-cycle pulse; plaintext valid from this cycle
- plaintext  output  BLOCK_W  result; held until the next completion
- keymem_addr  output  ADDR_W  registered subkey address; addr a holds round key K(a+1), so addr 31 = K32
- subkey  input  BLOCK_W  synchronous-read data, valid one clock after keymem_addr presents an address

Behaviour:
- Reset values: busy=0, ready=0, plaintext=0, keymem_addr=31, state=IDLE, data register=0. Reset is asynchronous and may occur mid-operation: the block returns to IDLE immediately and discards the partial block.
- FSM states: IDLE, FETCH, WHITEN, ROUND.
- IDLE, start=1 at edge E0:
  - latch ciphertext into the data register
  - keymem_addr<=31, busy<=1, go to FETCH
- FETCH, edge E1: keymem_addr<=30, go to WHITEN. subkey=K32 is now valid.
- WHITEN, edge E2: data<=data XOR subkey (K32), keymem_addr<=29, round counter<=ROUNDS, go to ROUND.
- ROUND, edges E3..E33, one inverse round per edge:
  - data <= invSbox(invPlayer(data)) XOR subkey
  - keymem_addr decrements, saturating at 0; don't-care after K1 has been issued
  - counter decrements
- ROUND, counter reaching 1 at edge E33:
  - plaintext<=result, ready<=1, busy<=0, keymem_addr<=31, go to IDLE
- Latency: ready is high in the cycle following E33, 33 clocks after the acceptance edge. Throughput is one block per 33 clocks.
- Inverse P-layer: input bit i moves to bit j, where the forward map is j = 16*i mod 63 for i<63 and j = 63 for i=63; the engine applies the inverse of that map.
- Inverse S-box per nibble, input 0..F -> 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- Handshake rules:
  - start while busy=1 is ignored, with no effect on the in-flight block.
  - start in the same cycle as ready=1 is accepted (the state is already IDLE), giving back-to-back operation.
  - ready deasserts after exactly one cycle.
- ciphertext changes after acceptance do not affect the result.

Optional Feature:
- Macro PRESENT_DEC_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in FETCH, WHITEN or ROUND returns the block to IDLE next edge with busy=0, ready=0, keymem_addr=31.
  - plaintext keeps its previous value, and the data register is cleared to 0.
  - abort has priority over the final-round transition.
  - abort in IDLE has no effect.
  - start and abort together in IDLE: start wins.
- Undefined: no abort port; an operation always runs to completion.

Decomposition:
- Shared package present_pkg:
  - INV_SBOX table
  - BLOCK_W and KEY_W(80) constants
  - ROUNDS and ADDR_W constants
  - state enum
  - inverse P-layer function
- One natural combinational sub-module, present_inv_round_layer: invPlayer then invSbox, 64 bits in / 64 out. It is instantiated once; the engine owns the XOR and all registers.

Test Plan:
- Bench models the subkey memory with 1-cycle read latency, loaded with the PRESENT-80 schedule for key=0. Ciphertext 5579C1387B228445 -> plaintext 0000000000000000; ready exactly 33 clocks after start.
- Key=0, ciphertext A112FFC72F68417B -> plaintext FFFFFFFFFFFFFFFF. Key=FFFFFFFFFFFFFFFFFFFF, ciphertext E72C46C0F5945049 -> 0000000000000000; ciphertext 3333DCD3213210D2 -> FFFFFFFFFFFFFFFF.
- keymem_addr trace: 31 on the cycle after start, then 30, 29, … 0 on successive cycles; each subkey consumed matches K(addr+1).
- start pulsed at cycles 5, 10 and 20 of a busy operation -> ignored; result unchanged; one ready pulse only. start asserted in the ready cycle -> second block completes 33 clocks later, correct.
- rst_in asserted at round 15 (asynchronously, between edges) -> busy/ready/plaintext at 0 immediately. A restart after reset decrypts correctly.
- With PRESENT_DEC_ABORT_EN: abort at round 10 -> busy=0 next cycle, no ready pulse, plaintext unchanged. The next start completes normally.
